// File: rtl/tawas_thread_sched_if.sv
// Control and issue signals between the config/bus units, the Tawas thread
// scheduler and the fetch/regfile front end.
interface tawas_thread_sched_if;
  logic        stall;
  logic        cfg_wr;
  logic [15:0] cfg_mask;
  logic        block_en;
  logic [3:0]  block_thread;
  logic        wake_en;
  logic [3:0]  wake_thread;
  logic        thread_start_en;
  logic [3:0]  thread_start;
  logic [15:0] enable_mask;
  logic [15:0] blocked_mask;
  logic        idle;

  modport master (
    output stall, cfg_wr, cfg_mask, block_en, block_thread, wake_en, wake_thread,
    input  thread_start_en, thread_start, enable_mask, blocked_mask, idle
  );

  modport slave (
    input  stall, cfg_wr, cfg_mask, block_en, block_thread, wake_en, wake_thread,
    output thread_start_en, thread_start, enable_mask, blocked_mask, idle
  );
endinterface

// File: rtl/tawas_thread_sched.sv
// Round-robin hardware-thread scheduler for the Tawas core: picks one of 16
// eligible threads per cycle and issues it to the regfile/fetch front end.
module tawas_thread_sched #(
  parameter int unsigned LOCKOUT    = 4,
  parameter logic [15:0] RESET_MASK = 16'h0001
) (
  input logic                 clk,
  input logic                 rst,
  tawas_thread_sched_if.slave bus
);

  // Counter is loaded with LOCKOUT-1 so the thread re-issues exactly LOCKOUT edges later.
  localparam logic [2:0] LOCK_LOAD = 3'(LOCKOUT - 1);

  logic [15:0] enable_q;
  logic [15:0] blocked_q;
  logic [3:0]  last_q;
  logic [2:0]  lock_cnt [16];
  logic        start_en_q;
  logic [3:0]  start_q;
  logic        idle_q;

  logic [15:0] eligible;
  logic [15:0] rotated;
  logic [3:0]  start_pt;
  logic [3:0]  offset;
  logic        found;
  logic [3:0]  sel;
  logic        issue;
  logic [15:0] en_next;
  logic [15:0] blk_next;

  always_comb begin
    for (int t = 0; t < 16; t++) begin
      eligible[t] = enable_q[t] & ~blocked_q[t] & (lock_cnt[t] == 3'd0);
    end
  end

  // Rotate so bit 0 is the thread after the last issued one; lowest set bit wins.
  always_comb begin
    start_pt = last_q + 4'd1;
    rotated  = 16'({eligible, eligible} >> start_pt);
    found    = 1'b0;
    offset   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = 4'(i);
      end
    end
    sel   = start_pt + offset;
    issue = found & ~bus.stall;
  end

  always_comb begin
    en_next  = bus.cfg_wr ? bus.cfg_mask : enable_q;
    blk_next = blocked_q & en_next;
    if (bus.block_en && en_next[bus.block_thread]) begin
      blk_next[bus.block_thread] = 1'b1;
    end
    if (bus.wake_en) begin
      blk_next[bus.wake_thread] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= RESET_MASK;
      blocked_q <= 16'h0000;
    end else begin
      enable_q  <= en_next;
      blocked_q <= blk_next;
    end
  end

  // Lockout counters drain only while the pipeline advances.
  always_ff @(posedge clk) begin
    for (int t = 0; t < 16; t++) begin
      if (rst) begin
        lock_cnt[t] <= 3'd0;
      end else if (!bus.stall) begin
        if (issue && (sel == 4'(t))) begin
          lock_cnt[t] <= LOCK_LOAD;
        end else if (lock_cnt[t] != 3'd0) begin
          lock_cnt[t] <= lock_cnt[t] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 4'hF;
      start_en_q <= 1'b0;
      start_q    <= 4'd0;
      idle_q     <= 1'b1;
    end else begin
      start_en_q <= issue;
      idle_q     <= ~issue;
      if (issue) begin
        start_q <= sel;
        last_q  <= sel;
      end
    end
  end

  assign bus.thread_start_en = start_en_q;
  assign bus.thread_start    = start_q;
  assign bus.enable_mask     = enable_q;
  assign bus.blocked_mask    = blocked_q;
  assign bus.idle            = idle_q;

endmodule
